// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) constant multipliers built from xtime,
// the state/column/byte typedefs, and the MixColumns engine FSM states.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [7:0]       aes_byte_t;
    typedef aes_byte_t [3:0]  aes_col_t;    // row r of a column = element r
    typedef aes_col_t  [3:0]  aes_state_t;  // column c = element c, 128 bits

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mc_state_e;

    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic aes_byte_t gmul2(input aes_byte_t b);
        return xtime(b);
    endfunction

    function automatic aes_byte_t gmul3(input aes_byte_t b);
        return xtime(b) ^ b;
    endfunction

    function automatic aes_byte_t gmul9(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic aes_byte_t gmulB(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic aes_byte_t gmulD(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic aes_byte_t gmulE(input aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Combinational single-column MixColumns / InvMixColumns; the inverse
// datapath exists only when SUPPORT_INV is set.
module aes_mix_column
    import aes_pkg::*;
#(
    parameter int SUPPORT_INV = 1
) (
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    aes_col_t a;
    aes_col_t fwd;

    assign a = col_in;

    always_comb begin
        fwd = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            fwd[2'(r)] = gmul2(a[2'(r)]) ^ gmul3(a[2'(r + 1)]) ^
                         a[2'(r + 2)] ^ a[2'(r + 3)];
        end
    end

    if (SUPPORT_INV != 0) begin : g_inv
        aes_col_t bwd;

        always_comb begin
            bwd = '0;
            for (int unsigned r = 0; r < 4; r++) begin
                bwd[2'(r)] = gmulE(a[2'(r)]) ^ gmulB(a[2'(r + 1)]) ^
                             gmulD(a[2'(r + 2)]) ^ gmul9(a[2'(r + 3)]);
            end
        end

        assign col_out = inv ? bwd : fwd;
    end else begin : g_fwd_only
        logic unused_inv;
        assign unused_inv = inv;
        assign col_out    = fwd;
    end

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Sequential AES MixColumns engine: accepts one state, transforms
// COLS_PER_CYCLE columns per clock in place, then holds the result for output.
module aes_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter int SUPPORT_INV    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

    mc_state_e  state;
    mc_state_e  state_next;
    aes_state_t work;
    aes_state_t work_next;
    aes_state_t mixed;
    logic [1:0] col_idx;
    logic [1:0] off;
    logic       mode;
    logic       accept;

    assign accept = in_valid && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (col_idx == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Slot k transforms column col_idx+k; unused slots are tied off so the
    // write-back mux below can index a full four-entry array.
    for (genvar k = 0; k < 4; k++) begin : g_col
        if (k < COLS_PER_CYCLE) begin : g_inst
            logic [1:0] sel;
            assign sel = col_idx + 2'(k);
            aes_mix_column #(
                .SUPPORT_INV(SUPPORT_INV)
            ) u_mix (
                .col_in (work[sel]),
                .inv    (mode),
                .col_out(mixed[k])
            );
        end else begin : g_tie
            assign mixed[k] = '0;
        end
    end

    always_comb begin
        work_next = work;
        off       = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            off = 2'(c) - col_idx;
            if ({1'b0, off} < 3'(COLS_PER_CYCLE)) begin
                work_next[2'(c)] = mixed[off];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work    <= '0;
            col_idx <= '0;
            mode    <= 1'b0;
        end else if (accept) begin
            work    <= in_data;
            col_idx <= '0;
            mode    <= in_inv && (SUPPORT_INV != 0);
        end else if (state == BUSY) begin
            work    <= work_next;
            col_idx <= col_idx + 2'(COLS_PER_CYCLE);
        end
    end

    assign out_data = (state == DONE) ? work : '0;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Bench for aes_mix_columns_seq: four instances (1/2/4 columns per cycle with
// inverse, 1 column without) checked against a GF(2^8) matrix-product model.
module tb_aes_mix_columns_seq;

    localparam int CPC  [4] = '{1, 2, 4, 1};
    localparam int SINV [4] = '{1, 1, 1, 0};

    logic         clk;
    logic         rst;
    logic         in_valid  [4];
    logic         in_ready  [4];
    logic [127:0] in_data   [4];
    logic         in_inv    [4];
    logic         out_valid [4];
    logic         out_ready [4];
    logic [127:0] out_data  [4];
    logic         busy      [4];

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        aes_mix_columns_seq #(
            .COLS_PER_CYCLE(CPC[g]),
            .SUPPORT_INV   (SINV[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .in_inv   (in_inv[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .busy     (busy[g])
        );
    end

    // Column written as in FIPS-197 (a0 first) -> packed column, a0 in low byte.
    function automatic logic [31:0] col(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [127:0] st(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
        return {col(c3), col(c2), col(c1), col(c0)};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        int x, y, p;
        x = int'(a);
        y = int'(b);
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if ((y & 1) != 0) p = p ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
            y = y >> 1;
        end
        return 8'(p);
    endfunction

    // Circulant matrix product per column: b_r = sum_j coef[(j-r) mod 4] * a_j.
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        r = '0;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gf_mul(s[c * 32 + j * 8 +: 8], coef[2'(j - rr)]);
                end
                r[c * 32 + rr * 8 +: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input logic [1:0] d);
        check($sformatf("rst_out_valid_d%0d", d), 128'(out_valid[d]), 128'(0));
        check($sformatf("rst_busy_d%0d", d), 128'(busy[d]), 128'(0));
        check($sformatf("rst_out_data_d%0d", d), out_data[d], '0);
    endtask

    task automatic start(input logic [1:0] d, input logic [127:0] data, input logic inv);
        int n;
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_inv[d]   = inv;
        n = 0;
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_ready_d%0d", d), 128'(in_ready[d]), 128'(1));
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_out(input logic [1:0] d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_out(input logic [1:0] d);
        @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        check($sformatf("post_hs_in_ready_d%0d", d), 128'(in_ready[d]), 128'(1));
        check($sformatf("post_hs_out_valid_d%0d", d), 128'(out_valid[d]), 128'(0));
    endtask

    task automatic run_kat(input logic [1:0] d, input logic [127:0] data, input logic inv,
                           input logic [127:0] exp, input string tag);
        int lat;
        start(d, data, inv);
        wait_out(d, lat);
        check({tag, "_latency"}, 128'(lat), 128'(4 / CPC[d]));
        check({tag, "_data"}, out_data[d], exp);
        check({tag, "_busy"}, 128'(busy[d]), 128'(1));
        finish_out(d);
    endtask

    task automatic backpressure(input logic [1:0] d);
        logic [127:0] blk;
        logic [127:0] exp;
        int           lat;
        blk = {$urandom, $urandom, $urandom, $urandom};
        exp = ref_mix(blk, 1'b0);
        start(d, blk, 1'b0);
        wait_out(d, lat);
        check($sformatf("bp_latency_d%0d", d), 128'(lat), 128'(4 / CPC[d]));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp_data_d%0d_c%0d", d, i), out_data[d], exp);
            check($sformatf("bp_in_ready_d%0d_c%0d", d, i), 128'(in_ready[d]), 128'(0));
            check($sformatf("bp_out_valid_d%0d_c%0d", d, i), 128'(out_valid[d]), 128'(1));
            in_valid[d] = 1'($urandom_range(0, 1));
            in_data[d]  = {$urandom, $urandom, $urandom, $urandom};
            in_inv[d]   = 1'($urandom_range(0, 1));
        end
        in_valid[d] = 1'b0;
        finish_out(d);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_idle_busy_d%0d_c%0d", d, i), 128'(busy[d]), 128'(0));
        end
    endtask

    task automatic b2b(input logic [1:0] d);
        logic [127:0] dq   [$];
        logic         iq   [$];
        int           acc  [$];
        logic [127:0] outs [$];
        logic [127:0] blk;
        logic         inv;
        int           cyc;
        cyc = 0;
        out_ready[d] = 1'b1;
        while (outs.size() < 8 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (out_valid[d]) outs.push_back(out_data[d]);
            if (in_ready[d]) begin
                if (dq.size() < 8) begin
                    blk = {$urandom, $urandom, $urandom, $urandom};
                    inv = 1'($urandom_range(0, 1));
                    in_valid[d] = 1'b1;
                    in_data[d]  = blk;
                    in_inv[d]   = inv;
                    dq.push_back(blk);
                    iq.push_back(inv);
                    acc.push_back(cyc);
                end else begin
                    in_valid[d] = 1'b0;
                end
            end
        end
        in_valid[d] = 1'b0;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        check($sformatf("b2b_count_d%0d", d), 128'(outs.size()), 128'(8));
        for (int i = 0; i < outs.size() && i < dq.size(); i++) begin
            check($sformatf("b2b_data_d%0d_%0d", d, i), outs[i],
                  ref_mix(dq[i], iq[i] && (SINV[d] != 0)));
        end
        for (int i = 1; i < acc.size(); i++) begin
            check($sformatf("b2b_ii_d%0d_%0d", d, i), 128'(acc[i] - acc[i - 1]),
                  128'(4 / CPC[d] + 2));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] fwd_in, fwd_out, inv_in, inv_out, blk;

        fwd_in  = st(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
        fwd_out = st(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
        inv_in  = st(32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8);
        inv_out = st(32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c);

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            in_inv[i]    = 1'b0;
            out_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) reset_checks(2'(i));
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_in_ready_d%0d", i), 128'(in_ready[i]), 128'(1));
        end

        for (int i = 0; i < 4; i++) begin
            run_kat(2'(i), fwd_in, 1'b0, fwd_out, $sformatf("kat_fwd_d%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            run_kat(2'(i), inv_in, 1'b1, inv_out, $sformatf("kat_inv_d%0d", i));
        end
        run_kat(2'd3, fwd_in, 1'b1, fwd_out, "noinv_fwd_d3");

        backpressure(2'd0);
        backpressure(2'd2);

        for (int i = 0; i < 4; i++) b2b(2'(i));

        blk = {$urandom, $urandom, $urandom, $urandom};
        start(2'd0, blk, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy_before", 128'(busy[0]), 128'(1));
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid[0]), 128'(0));
        check("midrst_busy", 128'(busy[0]), 128'(0));
        check("midrst_out_data", out_data[0], '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 128'(in_ready[0]), 128'(1));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("midrst_no_output_c%0d", i), 128'(out_valid[0]), 128'(0));
        end
        run_kat(2'd0, '0, 1'b0, '0, "post_rst_zero");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_mix_columns_seq.md
Name: aes_mix_columns_seq

Overview:
Sequential, parametrised AES MixColumns engine with a valid/ready handshake on both sides. It takes one 128-bit AES state and processes COLS_PER_CYCLE columns per clock. It supports forward MixColumns (encrypt) and, optionally, InvMixColumns (decrypt). It sits between the ShiftRows and AddRoundKey stages of the round datapath.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.
SUPPORT_INV, 1, 1 = in_inv selects InvMixColumns; 0 = inverse logic is omitted and in_inv is ignored (treated as 0).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
in_valid  in  1  input block valid.
in_ready  out  1  engine can accept a block.
in_data  in  128  AES state; byte i = in_data[8i+7:8i]; column c = bytes 4c..4c+3; row r of column c = byte 4c+r.
in_inv  in  1  0 = MixColumns, 1 = InvMixColumns; sampled at accept.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  128  transformed state, same byte mapping as in_data.
busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset is asynchronous and active-high, on clk/rst. While rst is high, all outputs are forced as follows:
  - state = IDLE; in_ready = 1 once rst falls.
  - out_valid = 0, busy = 0, out_data = 0.
  - Internal state register, column index and mode bit = 0.
- FSM states:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch in_data into the working register, latch the mode bit, set col_idx = 0, go to BUSY.
  - BUSY: in_ready = 0. Each clock, replace columns col_idx .. col_idx+COLS_PER_CYCLE-1 of the working register with their transformed values, then advance col_idx by COLS_PER_CYCLE. After the edge that processes column 3, go to DONE.
  - DONE: out_valid = 1 and out_data = working register. Both are held stable until out_ready. On out_valid & out_ready, go to IDLE.
- No same-cycle re-accept in DONE; in_ready rises the cycle after the output handshake.
- Latency: N = 4/COLS_PER_CYCLE. out_valid is asserted N cycles after the accept edge. Initiation interval = N+2 cycles when out_ready is held high.
- out_ready while not out_valid is ignored.
- in_valid while in_ready = 0 is ignored; the upstream holds data (AXI-style). in_data and in_inv are only sampled at the accept edge.
- Arithmetic in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1:
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).
  - Multiplication by constants is built from xtime/XOR only; no general multiplier and no iterative multiply.
- Forward transform, column (a0..a3), indices mod 4:
  - b_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3).
- Inverse transform:
  - b_r = 0E·a_r ^ 0B·a_(r+1) ^ 0D·a_(r+2) ^ 09·a_(r+3).
- Column transform logic is purely combinational. The only registers are the working register, col_idx, the mode bit and the FSM.
- Reset asserted mid-operation aborts the in-flight block. Nothing is output and the block is discarded.
- With SUPPORT_INV = 0, in_inv = 1 produces the forward transform.

Decomposition:
- Shared package aes_pkg holds:
  - AES_POLY = 8'h1B.
  - Functions xtime, gmul2, gmul3, gmul9, gmulB, gmulD, gmulE.
  - Typedefs aes_byte_t (8 bits), aes_col_t (4 bytes), aes_state_t (128 bits).
  - FSM state enum (IDLE, BUSY, DONE).
- One sub-module, aes_mix_column: combinational, one 32-bit column plus an inv input, producing one 32-bit column. The top module instantiates COLS_PER_CYCLE copies. The inverse path inside aes_mix_column is generated only when SUPPORT_INV = 1.

Test Plan:
- Reset then forward block (all COLS_PER_CYCLE values):
  - Stimulus: columns db135345, f20a225c, 01010101, c6c6c6c6, inv = 0.
  - Required response: out_data columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6. out_valid rises exactly 4/2/1 cycles after accept.
- Inverse round trip (SUPPORT_INV = 1):
  - Stimulus: columns 8e4da1bc, 9fdc589d, d5d5d7d6, 4d7ebdf8, inv = 1.
  - Required response: db135345, f20a225c, d4d4d4d5, 2d26314c.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles after out_valid.
  - Required response: out_data stable, in_ready = 0 throughout, in_valid pulses ignored. Releasing out_ready completes the handshake and in_ready = 1 the next cycle.
- Back-to-back:
  - Stimulus: 8 random blocks with in_valid and out_ready held high, random inv.
  - Required response: matches the reference model; initiation interval = N+2 cycles.
- Reset mid-BUSY:
  - Stimulus: assert rst two cycles after accept (COLS_PER_CYCLE = 1).
  - Required response: out_valid = 0 and busy = 0 immediately, asynchronously. After release, a new block (all-zero state) produces all-zero output.
- SUPPORT_INV = 0 build:
  - Stimulus: the block from the first scenario with inv = 1.
  - Required response: the forward result 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6.
